// File: rtl/mac_buf_ctrl_pkg.sv
// mac_buf_ctrl_pkg: shared FSM states and default buffer geometry
package mac_buf_ctrl_pkg;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, FLUSH} state_t;
  localparam int DefBufferWidth = 2;
  localparam int DefBufferSize = 4;
endpackage

// File: rtl/mac_buf_ctrl_occupancy_mask.sv
// occupancy_mask: per-entry occupancy derived from the ring pointers
module occupancy_mask #(
  parameter int BufferWidth = 2,
  parameter int BufferSize = 4
) (
  input  logic [BufferWidth-1:0] W_Addr,
  input  logic [BufferWidth-1:0] R_Addr,
  input  logic                   Round,
  output logic [BufferSize-1:0]  Ready
);
  for (genvar i = 0; i < BufferSize; i++) begin : g_ent
    assign Ready[i] = Round ? (BufferWidth'(i) >= R_Addr || BufferWidth'(i) < W_Addr)
                            : (BufferWidth'(i) >= R_Addr && BufferWidth'(i) < W_Addr);
  end
endmodule

// File: rtl/mac_buf_ctrl.sv
// mac_buf_ctrl: ring-buffer pointer/flow control for the MAC operand buffer
module mac_buf_ctrl
  import mac_buf_ctrl_pkg::*;
#(
  parameter int BufferWidth = DefBufferWidth,
  parameter int BufferSize = DefBufferSize
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  input  logic                   flush,
  output logic                   wr_en,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic [BufferSize-1:0]  Ready,
  output logic [BufferWidth:0]   count
);
  state_t state, nxt_state;
  logic full, empty, push, pop, w_wrap, r_wrap;
  logic [BufferWidth:0] nxt_count;
  assign empty = W_Addr == R_Addr && !Round;
  assign full = W_Addr == R_Addr && Round;
  assign wr_ready = !rst && !full && state != FLUSH;
  assign rd_valid = !empty && state != FLUSH;
  assign wr_en = wr_valid && wr_ready && !flush;
  assign push = wr_en;
  assign pop = rd_valid && rd_ready && !flush;
  assign w_wrap = push && W_Addr == BufferWidth'(BufferSize - 1);
  assign r_wrap = pop && R_Addr == BufferWidth'(BufferSize - 1);
  // Round marks the write pointer one lap ahead, so it extends W_Addr as the MSB
  assign count = {Round, W_Addr} - {1'b0, R_Addr};
  assign nxt_count = count + {{BufferWidth{1'b0}}, push} - {{BufferWidth{1'b0}}, pop};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_Addr <= '0;
      R_Addr <= '0;
      Round <= 1'b0;
    end else if (flush) begin
      W_Addr <= '0;
      R_Addr <= '0;
      Round <= 1'b0;
    end else begin
      if (push) W_Addr <= W_Addr + BufferWidth'(1);
      if (pop) R_Addr <= R_Addr + BufferWidth'(1);
      Round <= Round ^ w_wrap ^ r_wrap;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else state <= nxt_state;
  end
  always_comb begin
    nxt_state = flush ? FLUSH
              : nxt_count == '0 ? EMPTY
              : nxt_count == (BufferWidth + 1)'(BufferSize) ? FULL
              : PARTIAL;
  end
  occupancy_mask #(.BufferWidth(BufferWidth), .BufferSize(BufferSize)) u_mask (
    .W_Addr(W_Addr),
    .R_Addr(R_Addr),
    .Round(Round),
    .Ready(Ready)
  );
endmodule

// File: tb/tb_mac_buf_ctrl.sv
// tb_mac_buf_ctrl: directed vector table plus reset/flush corner sequences
module tb_mac_buf_ctrl;
  import mac_buf_ctrl_pkg::*;
  logic clk, rst, wr_valid, wr_ready, rd_valid, rd_ready, flush, wr_en, Round;
  logic [1:0] W_Addr, R_Addr;
  logic [3:0] Ready;
  logic [2:0] count;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic wv, rr, fl, wen;
    int cnt;
    logic [3:0] rdy;
    int w, r;
    logic rnd, wrdy, rdv;
    state_t st;
  } vec_t;
  vec_t v[26];
  mac_buf_ctrl dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .flush(flush), .wr_en(wr_en), .W_Addr(W_Addr), .R_Addr(R_Addr),
    .Round(Round), .Ready(Ready), .count(count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input vec_t e);
    chk("count", int'(count), e.cnt);
    chk("Ready", int'(Ready), int'(e.rdy));
    chk("W_Addr", int'(W_Addr), e.w);
    chk("R_Addr", int'(R_Addr), e.r);
    chk("Round", int'(Round), int'(e.rnd));
    chk("wr_ready", int'(wr_ready), int'(e.wrdy));
    chk("rd_valid", int'(rd_valid), int'(e.rdv));
    chk("state", int'(dut.state), int'(e.st));
  endtask
  initial begin
    v[0]  = '{1,0,0,1, 1,4'b0001, 1,0,0, 1,1, PARTIAL};
    v[1]  = '{1,0,0,1, 2,4'b0011, 2,0,0, 1,1, PARTIAL};
    v[2]  = '{1,0,0,1, 3,4'b0111, 3,0,0, 1,1, PARTIAL};
    v[3]  = '{1,0,0,1, 4,4'b1111, 0,0,1, 0,1, FULL};
    v[4]  = '{1,0,0,0, 4,4'b1111, 0,0,1, 0,1, FULL};
    v[5]  = '{1,1,0,0, 3,4'b1110, 0,1,1, 1,1, PARTIAL};
    v[6]  = '{1,0,0,1, 4,4'b1111, 1,1,1, 0,1, FULL};
    v[7]  = '{0,1,0,0, 3,4'b1101, 1,2,1, 1,1, PARTIAL};
    v[8]  = '{0,1,0,0, 2,4'b1001, 1,3,1, 1,1, PARTIAL};
    v[9]  = '{0,1,0,0, 1,4'b0001, 1,0,0, 1,1, PARTIAL};
    v[10] = '{0,1,0,0, 0,4'b0000, 1,1,0, 1,0, EMPTY};
    v[11] = '{0,1,0,0, 0,4'b0000, 1,1,0, 1,0, EMPTY};
    v[12] = '{1,0,0,1, 1,4'b0010, 2,1,0, 1,1, PARTIAL};
    v[13] = '{1,0,0,1, 2,4'b0110, 3,1,0, 1,1, PARTIAL};
    v[14] = '{0,1,0,0, 1,4'b0100, 3,2,0, 1,1, PARTIAL};
    v[15] = '{0,1,0,0, 0,4'b0000, 3,3,0, 1,0, EMPTY};
    v[16] = '{1,0,0,1, 1,4'b1000, 0,3,1, 1,1, PARTIAL};
    v[17] = '{1,0,0,1, 2,4'b1001, 1,3,1, 1,1, PARTIAL};
    v[18] = '{1,0,0,1, 3,4'b1011, 2,3,1, 1,1, PARTIAL};
    v[19] = '{1,0,0,1, 4,4'b1111, 3,3,1, 0,1, FULL};
    v[20] = '{1,1,0,0, 3,4'b0111, 3,0,0, 1,1, PARTIAL};
    v[21] = '{1,1,0,1, 3,4'b1110, 0,1,1, 1,1, PARTIAL};
    v[22] = '{1,0,1,0, 0,4'b0000, 0,0,0, 0,0, FLUSH};
    v[23] = '{0,0,0,0, 0,4'b0000, 0,0,0, 1,0, EMPTY};
    v[24] = '{1,0,0,1, 1,4'b0001, 1,0,0, 1,1, PARTIAL};
    v[25] = '{1,0,0,1, 2,4'b0011, 2,0,0, 1,1, PARTIAL};
    rst = 1; wr_valid = 1; rd_ready = 1; flush = 0;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk_all('{0,0,0,0, 0,4'b0000, 0,0,0, 0,0, EMPTY});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; wr_valid = 0; rd_ready = 0;
    #1;
    chk("post_rst_wr_ready", int'(wr_ready), 1);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      wr_valid = v[k].wv; rd_ready = v[k].rr; flush = v[k].fl;
      #1;
      chk($sformatf("wr_en[%0d]", k), int'(wr_en), int'(v[k].wen));
      @(posedge clk);
      #1;
      chk_all(v[k]);
    end
    @(negedge clk);
    wr_valid = 1; rd_ready = 0; flush = 0;
    #2;
    rst = 1;
    #1;
    chk_all('{0,0,0,0, 0,4'b0000, 0,0,0, 0,0, EMPTY});
    chk("async_rst_wr_en", int'(wr_en), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("first_push_wr_en", int'(wr_en), 1);
    chk("first_push_W_Addr", int'(W_Addr), 0);
    @(posedge clk);
    #1;
    chk_all('{0,0,0,0, 1,4'b0001, 1,0,0, 1,1, PARTIAL});
    @(negedge clk);
    wr_valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
